wb_axi_addr_queue: RTL and testbench
====================================

# wb_axi_addr_queue

Wishbone-to-AXI address-channel converter with a parametrised outstanding-request queue, burst lengths, automatic transaction IDs and 4 KB boundary protection. Sits between the CPU-side Wishbone request decode and the AXI AR or AW channel of the bridge. Lets the CPU post up to DEPTH address requests before the interconnect accepts the first one. One instance per direction, selected by CHANNEL.

## Interface
- ADDR_WIDTH, 32, address width
- ID_WIDTH, 4, AXI ID width; also the width of the ID counter
- DATA_WIDTH, 32, AXI data width (8–1024, power of 2); fixes axsize = log2(DATA_WIDTH/8)
- DEPTH, 4, queue entries (power of 2, ≥2)
- CHANNEL, "READ", "READ" accepts only wb_we=0; "WRITE" accepts only wb_we=1

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset; asynchronous, active-low
- wb_adr  in  ADDR_WIDTH  request start address
- wb_cyc, wb_stb, wb_we  in  1 each  Wishbone request qualifiers
- req_len  in  8  burst beats minus 1 (AXI axlen encoding)
- req_ready  out  1  queue not full (combinational)
- req_ack  out  1  one-cycle pulse: request consumed
- req_err  out  1  one-cycle pulse with req_ack: request dropped, crosses 4 KB
- req_id  out  ID_WIDTH  ID assigned to the acked request; valid with req_ack
- axi_axid, axi_axaddr, axi_axlen  out  ID_WIDTH / ADDR_WIDTH / 8  head-entry payload
- axi_axsize  out  3  constant log2(DATA_WIDTH/8)
- axi_axburst  out  2  constant 2'b01 (INCR)
- axi_axlock  out  2  constant 2'b00
- axi_axcache  out  4  constant 4'b0011
- axi_axprot  out  3  constant 3'b000
- axi_axqos, axi_axregion  out  4 each  constant 0
- axi_axvalid  out  1  queue not empty
- axi_axready  in  1  slave accepts the head entry
- occupancy  out  $clog2(DEPTH)+1  number of entries queued

## Operation
- **Request definition:** wb_cyc & wb_stb & (wb_we matches CHANNEL). Requests with the wrong wb_we are ignored: no ack, no queueing.
- **Consume:** request & req_ready at a rising edge. req_ack pulses for one cycle in the next cycle.
- **4 KB check:** end = wb_adr + (req_len+1)·(DATA_WIDTH/8) − 1, computed at ADDR_WIDTH+1 bits. If end[ADDR_WIDTH:12] ≠ wb_adr[ADDR_WIDTH-1:12], the request is consumed but not queued. req_ack and req_err pulse together, and the ID counter does not advance.
- **Push:** a legal request writes {id_cnt, wb_adr, req_len} into the tail entry. req_id = id_cnt, then id_cnt increments, wrapping modulo 2^ID_WIDTH.
- **Pop:** axi_axvalid & axi_axready pops the head entry.
- **Payload stability:** while axi_axvalid=1 and axi_axready=0, all AXI payload outputs are stable.
- **Push/pop priority:**
  - Simultaneous push and pop when not full or empty: both happen, occupancy unchanged.
  - Push when full: not allowed. req_ready is 0 even if a pop happens that cycle; there is no pop-through.
  - Push into an empty queue: no bypass. The entry is visible the following cycle.
- **Pointers:** read and write pointers are $clog2(DEPTH) bits with wrap. full = occupancy==DEPTH, empty = occupancy==0.
- **Reset:** asynchronous assert flushes the queue mid-operation. Entries are discarded and not replayed.

## Timing
- Reset values:
  - axi_axvalid=0, occupancy=0, req_ready=1, req_ack=0, req_err=0, req_id=0, id_cnt=0.
  - axi_axid=0, axi_axaddr=0, axi_axlen=0.
  - Constant outputs hold the values listed under Interface.
- Latency: request consumed at edge N → axi_axvalid=1 from edge N (visible cycle N+1). Best-case request-to-handshake is 1 cycle.
- Throughput: one push and one pop per cycle sustained.
- req_ready depends only on occupancy (registered), never on axi_axready.
- axi_axvalid, once high, stays high until a handshake (AXI rule).

## Structure
- **Package `wb_axi_pkg`:**
  - Constants: AXI_BURST_INCR, AXI_LOCK_NORMAL, AXI_CACHE_BUFFERABLE, AXI_PROT_DEFAULT, AXI_4KB_SHIFT=12.
  - Function clog2_size(DATA_WIDTH), shared with the data-channel converters.
- **Sub-module `axi_addr_fifo`:** generic synchronous FIFO with parameters WIDTH and DEPTH. Provides push, pop, full, empty, count and a head read port. The top level holds the request decode, the 4 KB check, the ID counter and the ack/err pulses.

## Test plan
- **Single read:** CHANNEL="READ", wb_adr=0x1000, req_len=0, axi_axready=1 → one AR at 0x1000, axid=0, axlen=0, axsize=2; req_ack one cycle; occupancy returns to 0.
- **Fill and drain:** DEPTH=4, axi_axready=0, 5 requests at 0x100,0x200,… → first 4 acked with ids 0–3; req_ready=0 and the 5th stalls. Raise axi_axready → addresses emerge in order and the 5th enters only after the first pop.
- **4 KB violation:** wb_adr=0x0FF0, req_len=7, DATA_WIDTH=32 (end 0x100F) → req_ack+req_err, no AR, next legal request gets the same ID.
- **Wrong direction:** CHANNEL="WRITE", wb_we=0 request → no ack, occupancy stays 0.
- **ID wrap and simultaneous push/pop:** 20 back-to-back requests with ID_WIDTH=4 and axi_axready toggling every cycle → axid sequence 0..15,0..3 in order; occupancy never exceeds 4; payload stable during every stall.
- **Reset mid-operation:** assert ARESETN low with 3 entries queued and valid stalled → axi_axvalid falls immediately and occupancy=0. After release, the first new request gets axid=0.

Source files
------------

// File: rtl/wb_axi_pkg.sv
// -----------------------------------------------------------------------------
// wb_axi_pkg
// Shared AXI constants and helpers for the Wishbone-to-AXI bridge.
//   AXI_BURST_INCR        : axburst encoding for incrementing bursts
//   AXI_LOCK_NORMAL       : axlock encoding for normal access
//   AXI_CACHE_BUFFERABLE  : axcache attribute driven on every request
//   AXI_PROT_DEFAULT      : axprot attribute driven on every request
//   AXI_4KB_SHIFT         : log2 of the AXI burst boundary (4 KB)
//   clog2_size()          : axsize encoding for a given data-bus width
// -----------------------------------------------------------------------------
package wb_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR       = 2'b01;
  localparam logic [1:0] AXI_LOCK_NORMAL      = 2'b00;
  localparam logic [3:0] AXI_CACHE_BUFFERABLE = 4'b0011;
  localparam logic [2:0] AXI_PROT_DEFAULT     = 3'b000;
  localparam int         AXI_4KB_SHIFT        = 12;

  // Bytes per beat expressed as an axsize code: log2(data_width / 8).
  function automatic logic [2:0] clog2_size(input int data_width);
    int         bytes;
    logic [2:0] size;
    size  = '0;
    bytes = data_width / 8;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == bytes) size = 3'(i);
    end
    return size;
  endfunction

endpackage

// File: rtl/axi_addr_fifo.sv
// -----------------------------------------------------------------------------
// axi_addr_fifo
// Generic synchronous FIFO, power-of-two DEPTH, first-word visible on data_o.
//   clk, rst_n : clock, asynchronous active-low reset (flushes contents)
//   push_i     : write data_i into the tail (ignored when full)
//   pop_i      : drop the head entry (ignored when empty)
//   data_o     : head entry, forced to zero while empty
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
//   count_o    : number of stored entries
// -----------------------------------------------------------------------------
module axi_addr_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         data_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PW'(1);
      if (do_pop)  rptr_q <= rptr_q + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale words are never observable
  // because the head is masked while empty, and a reset-free array maps to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign data_o = empty_o ? '0 : mem_q[rptr_q];

endmodule

// File: rtl/wb_axi_addr_queue.sv
// -----------------------------------------------------------------------------
// wb_axi_addr_queue
// Converts Wishbone requests into AXI AR or AW address beats through a
// DEPTH-entry queue, assigning rolling IDs and rejecting bursts that would
// cross a 4 KB boundary.
//   ACLK, ARESETN             : clock, asynchronous active-low reset
//   wb_adr/cyc/stb/we, req_len: request from the Wishbone decode
//   req_ready                 : queue has space (depends on occupancy only)
//   req_ack / req_err / req_id: one-cycle result of a consumed request
//   axi_ax*                   : AXI address channel (head entry + constants)
//   occupancy                 : entries currently queued
// -----------------------------------------------------------------------------
module wb_axi_addr_queue
  import wb_axi_pkg::*;
#(
  parameter int    ADDR_WIDTH = 32,
  parameter int    ID_WIDTH   = 4,
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 4,
  parameter string CHANNEL    = "READ"
) (
  input  logic                    ACLK,
  input  logic                    ARESETN,
  input  logic [ADDR_WIDTH-1:0]   wb_adr,
  input  logic                    wb_cyc,
  input  logic                    wb_stb,
  input  logic                    wb_we,
  input  logic [7:0]              req_len,
  output logic                    req_ready,
  output logic                    req_ack,
  output logic                    req_err,
  output logic [ID_WIDTH-1:0]     req_id,
  output logic [ID_WIDTH-1:0]     axi_axid,
  output logic [ADDR_WIDTH-1:0]   axi_axaddr,
  output logic [7:0]              axi_axlen,
  output logic [2:0]              axi_axsize,
  output logic [1:0]              axi_axburst,
  output logic [1:0]              axi_axlock,
  output logic [3:0]              axi_axcache,
  output logic [2:0]              axi_axprot,
  output logic [3:0]              axi_axqos,
  output logic [3:0]              axi_axregion,
  output logic                    axi_axvalid,
  input  logic                    axi_axready,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam logic       IS_WRITE = (CHANNEL == "WRITE");
  localparam logic [2:0] AXSIZE   = clog2_size(DATA_WIDTH);
  localparam int         AW1      = ADDR_WIDTH + 1;
  localparam int         FW       = ID_WIDTH + ADDR_WIDTH + 8;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
  } entry_t;

  logic                wb_req, consume, crosses, push;
  logic [AW1-1:0]      span, end_addr;
  entry_t              tail_entry, head_entry;
  logic                fifo_full, fifo_empty;

  logic                ack_q, ack_d;
  logic                err_q, err_d;
  logic [ID_WIDTH-1:0] req_id_q, req_id_d;
  logic [ID_WIDTH-1:0] id_cnt_q, id_cnt_d;

  // Requests of the other direction are invisible to this instance.
  assign wb_req  = wb_cyc & wb_stb & (wb_we == IS_WRITE);
  assign consume = wb_req & req_ready;

  // Last byte of the burst, one bit wider than the address so a wrap past the
  // top of the address space also registers as a page change.
  assign span     = (AW1'(req_len) + AW1'(1)) << AXSIZE;
  assign end_addr = AW1'(wb_adr) + span - AW1'(1);
  assign crosses  = (end_addr >> AXI_4KB_SHIFT) != (AW1'(wb_adr) >> AXI_4KB_SHIFT);

  assign push = consume & ~crosses;

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    ack_d    = consume;
    err_d    = consume & crosses;
    req_id_d = req_id_q;
    id_cnt_d = id_cnt_q;
    if (push) begin
      req_id_d = id_cnt_q;
      id_cnt_d = id_cnt_q + ID_WIDTH'(1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      req_id_q <= '0;
      id_cnt_q <= '0;
    end else begin
      ack_q    <= ack_d;
      err_q    <= err_d;
      req_id_q <= req_id_d;
      id_cnt_q <= id_cnt_d;
    end
  end

  assign tail_entry = '{id: id_cnt_q, addr: wb_adr, len: req_len};

  axi_addr_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (ACLK),
    .rst_n   (ARESETN),
    .push_i  (push),
    .pop_i   (axi_axready),
    .data_i  (tail_entry),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (occupancy)
  );

  // No pop-through: a full queue refuses requests even if the head leaves now.
  assign req_ready   = ~fifo_full;
  assign req_ack     = ack_q;
  assign req_err     = err_q;
  assign req_id      = req_id_q;

  assign axi_axvalid  = ~fifo_empty;
  assign axi_axid     = head_entry.id;
  assign axi_axaddr   = head_entry.addr;
  assign axi_axlen    = head_entry.len;
  assign axi_axsize   = AXSIZE;
  assign axi_axburst  = AXI_BURST_INCR;
  assign axi_axlock   = AXI_LOCK_NORMAL;
  assign axi_axcache  = AXI_CACHE_BUFFERABLE;
  assign axi_axprot   = AXI_PROT_DEFAULT;
  assign axi_axqos    = 4'b0000;
  assign axi_axregion = 4'b0000;

endmodule

// File: tb/tb_wb_axi_addr_queue.sv
// -----------------------------------------------------------------------------
// tb_wb_axi_addr_queue
// Directed bench for a READ-channel wb_axi_addr_queue (DEPTH=4, ID_WIDTH=4,
// DATA_WIDTH=32). Accepted requests are queued as expected AR beats and
// compared in order when the address handshake occurs.
// -----------------------------------------------------------------------------
module tb_wb_axi_addr_queue;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] wb_adr;
  logic        wb_cyc, wb_stb, wb_we;
  logic [7:0]  req_len;
  logic        req_ready, req_ack, req_err;
  logic [3:0]  req_id;
  logic [3:0]  axi_axid;
  logic [31:0] axi_axaddr;
  logic [7:0]  axi_axlen;
  logic [2:0]  axi_axsize;
  logic [1:0]  axi_axburst, axi_axlock;
  logic [3:0]  axi_axcache;
  logic [2:0]  axi_axprot;
  logic [3:0]  axi_axqos, axi_axregion;
  logic        axi_axvalid, axi_axready;
  logic [2:0]  occupancy;

  wb_axi_addr_queue #(
    .ADDR_WIDTH (32),
    .ID_WIDTH   (4),
    .DATA_WIDTH (32),
    .DEPTH      (4),
    .CHANNEL    ("READ")
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .wb_adr       (wb_adr),
    .wb_cyc       (wb_cyc),
    .wb_stb       (wb_stb),
    .wb_we        (wb_we),
    .req_len      (req_len),
    .req_ready    (req_ready),
    .req_ack      (req_ack),
    .req_err      (req_err),
    .req_id       (req_id),
    .axi_axid     (axi_axid),
    .axi_axaddr   (axi_axaddr),
    .axi_axlen    (axi_axlen),
    .axi_axsize   (axi_axsize),
    .axi_axburst  (axi_axburst),
    .axi_axlock   (axi_axlock),
    .axi_axcache  (axi_axcache),
    .axi_axprot   (axi_axprot),
    .axi_axqos    (axi_axqos),
    .axi_axregion (axi_axregion),
    .axi_axvalid  (axi_axvalid),
    .axi_axready  (axi_axready),
    .occupancy    (occupancy)
  );

  always #5 ACLK = ~ACLK;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         n_hs     = 0;
  logic [3:0] exp_id   = '0;
  logic       prev_stall = 1'b0;
  exp_t       prev_pay;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Address-channel monitor: in-order scoreboard plus stall stability.
  always @(negedge ACLK) begin
    exp_t e;
    if (ARESETN) begin
      if (prev_stall) begin
        check("stall_valid_held", 64'(axi_axvalid), 64'd1);
        check("stall_payload", 64'({axi_axid, axi_axaddr, axi_axlen}), 64'(prev_pay));
      end
      if (axi_axvalid && axi_axready) begin
        check("ar_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("ar_id",   64'(axi_axid),   64'(e.id));
          check("ar_addr", 64'(axi_axaddr), 64'(e.addr));
          check("ar_len",  64'(axi_axlen),  64'(e.len));
          n_hs++;
        end
      end
      prev_stall = axi_axvalid && !axi_axready;
      prev_pay   = '{id: axi_axid, addr: axi_axaddr, len: axi_axlen};
    end else begin
      prev_stall = 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // One request presented for one edge; outcome checked right after that edge.
  task automatic do_req(input logic [31:0] adr, input logic [7:0] len, input logic we,
                        input logic exp_ack, input logic exp_err);
    wb_adr = adr; req_len = len; wb_we = we; wb_cyc = 1'b1; wb_stb = 1'b1;
    @(posedge ACLK); #1;
    check("req_ack", 64'(req_ack), 64'(exp_ack));
    check("req_err", 64'(req_err), 64'(exp_err));
    if (exp_ack && !exp_err) begin
      check("req_id", 64'(req_id), 64'(exp_id));
      sb.push_back('{id: exp_id, addr: adr, len: len});
      exp_id = exp_id + 4'd1;
    end
    wb_cyc = 1'b0; wb_stb = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 50; i++) begin
      if (occupancy == 3'd0) break;
      @(posedge ACLK); #1;
    end
    check("drain_occupancy", 64'(occupancy), 64'd0);
    check("drain_scoreboard", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int n, cycles;
    ARESETN = 1'b0; wb_adr = '0; wb_cyc = 0; wb_stb = 0; wb_we = 0; req_len = '0;
    axi_axready = 1'b0;

    // Reset values and constant outputs.
    #12;
    check("rst_valid",   64'(axi_axvalid),  64'd0);
    check("rst_occ",     64'(occupancy),    64'd0);
    check("rst_ready",   64'(req_ready),    64'd1);
    check("rst_ack",     64'(req_ack),      64'd0);
    check("rst_err",     64'(req_err),      64'd0);
    check("rst_id",      64'(req_id),       64'd0);
    check("rst_payload", 64'({axi_axid, axi_axaddr, axi_axlen}), 64'd0);
    check("axsize",      64'(axi_axsize),   64'd2);
    check("axburst",     64'(axi_axburst),  64'd1);
    check("axlock",      64'(axi_axlock),   64'd0);
    check("axcache",     64'(axi_axcache),  64'd3);
    check("axprot",      64'(axi_axprot),   64'd0);
    check("axqos_region", 64'({axi_axqos, axi_axregion}), 64'd0);
    @(negedge ACLK); ARESETN = 1'b1;
    @(posedge ACLK); #1;

    // Single read, slave always ready.
    axi_axready = 1'b1;
    do_req(32'h0000_1000, 8'd0, 1'b0, 1'b1, 1'b0);
    check("single_valid_next", 64'(axi_axvalid), 64'd1);
    @(posedge ACLK); #1;
    check("single_ack_pulse", 64'(req_ack), 64'd0);
    check("single_occ", 64'(occupancy), 64'd0);
    check("single_hs", 64'(n_hs), 64'd1);

    // Fill with the slave stalled, fifth request must wait for the first pop.
    axi_axready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      check("fill_ready", 64'(req_ready), 64'd1);
      do_req(32'(i * 32'h100), 8'(i), 1'b0, 1'b1, 1'b0);
    end
    check("full_occ", 64'(occupancy), 64'd4);
    check("full_ready", 64'(req_ready), 64'd0);
    wb_adr = 32'h0000_0500; req_len = 8'd5; wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge ACLK); #1;
      check("stalled_ack", 64'(req_ack), 64'd0);
      check("stalled_occ", 64'(occupancy), 64'd4);
    end
    axi_axready = 1'b1;
    @(posedge ACLK); #1;
    check("no_popthrough_ack", 64'(req_ack), 64'd0);
    check("after_pop_occ", 64'(occupancy), 64'd3);
    sb.push_back('{id: exp_id, addr: 32'h0000_0500, len: 8'd5});
    @(posedge ACLK); #1;
    check("fifth_ack", 64'(req_ack), 64'd1);
    check("fifth_id", 64'(req_id), 64'(exp_id));
    check("pushpop_occ", 64'(occupancy), 64'd3);
    exp_id = exp_id + 4'd1;
    wb_cyc = 1'b0; wb_stb = 1'b0;
    drain();

    // 4 KB boundary: violations are acked with err and do not use an ID.
    do_req(32'h0000_0FF0, 8'd7, 1'b0, 1'b1, 1'b1);
    check("err_no_valid", 64'(axi_axvalid), 64'd0);
    @(posedge ACLK); #1;
    check("err_occ", 64'(occupancy), 64'd0);
    do_req(32'h0000_0FFC, 8'd0, 1'b0, 1'b1, 1'b0);
    do_req(32'hFFFF_FFF0, 8'd7, 1'b0, 1'b1, 1'b1);
    do_req(32'h0000_0FF0, 8'd3, 1'b0, 1'b1, 1'b0);
    drain();

    // Wrong direction and incomplete qualifiers are ignored.
    wb_adr = 32'h0000_4000; req_len = 8'd0; wb_we = 1'b1; wb_cyc = 1'b1; wb_stb = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge ACLK); #1;
      check("wrong_dir_ack", 64'(req_ack), 64'd0);
      check("wrong_dir_occ", 64'(occupancy), 64'd0);
    end
    wb_we = 1'b0; wb_stb = 1'b0;
    @(posedge ACLK); #1;
    check("no_stb_ack", 64'(req_ack), 64'd0);
    check("no_stb_valid", 64'(axi_axvalid), 64'd0);
    wb_cyc = 1'b0;

    // Twenty back-to-back requests with the slave toggling: ID wrap and
    // simultaneous push/pop.
    n = 0; cycles = 0;
    while (n < 20 && cycles < 200) begin
      wb_adr = 32'h0000_2000 + 32'(n * 16); req_len = 8'(n % 4);
      wb_we = 1'b0; wb_cyc = 1'b1; wb_stb = 1'b1;
      axi_axready = cycles[0];
      @(posedge ACLK); #1;
      if (req_ack) begin
        check("burst_err", 64'(req_err), 64'd0);
        check("burst_id", 64'(req_id), 64'(exp_id));
        sb.push_back('{id: exp_id, addr: 32'h0000_2000 + 32'(n * 16), len: 8'(n % 4)});
        exp_id = exp_id + 4'd1;
        n++;
      end
      check("burst_occ_max", 64'(occupancy <= 3'd4), 64'd1);
      cycles++;
    end
    check("burst_all_acked", 64'(n), 64'd20);
    wb_cyc = 1'b0; wb_stb = 1'b0;
    axi_axready = 1'b1;
    drain();

    // Reset with three entries stalled: queue flushed, IDs restart.
    axi_axready = 1'b0;
    for (int i = 0; i < 3; i++) do_req(32'h0000_5000 + 32'(i * 32'h100), 8'd1, 1'b0, 1'b1, 1'b0);
    check("pre_rst_occ", 64'(occupancy), 64'd3);
    check("pre_rst_valid", 64'(axi_axvalid), 64'd1);
    @(posedge ACLK); #3;
    ARESETN = 1'b0;
    #1;
    check("async_rst_valid", 64'(axi_axvalid), 64'd0);
    check("async_rst_occ", 64'(occupancy), 64'd0);
    check("async_rst_ready", 64'(req_ready), 64'd1);
    sb.delete();
    exp_id = '0;
    @(posedge ACLK);
    @(negedge ACLK); ARESETN = 1'b1;
    @(posedge ACLK); #1;
    check("post_rst_ack", 64'(req_ack), 64'd0);
    axi_axready = 1'b1;
    do_req(32'h0000_6000, 8'd1, 1'b0, 1'b1, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
